// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART baud generator.
//   BAUD_SEL_W  - width of a rate selection code
//   NUM_RATES   - number of selectable rates
//   BAUD_RATES  - baud rate per selection code
//   baud_sel_e  - named selection codes
//   baud_div()  - rounded clock divisor for one oversample period
package uart_pkg;

  localparam int BAUD_SEL_W = 3;
  localparam int NUM_RATES  = 8;

  localparam int BAUD_RATES [NUM_RATES] = '{
    2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400
  };

  typedef enum logic [BAUD_SEL_W-1:0] {
    BAUD_2400   = 3'd0,
    BAUD_4800   = 3'd1,
    BAUD_9600   = 3'd2,
    BAUD_19200  = 3'd3,
    BAUD_38400  = 3'd4,
    BAUD_57600  = 3'd5,
    BAUD_115200 = 3'd6,
    BAUD_230400 = 3'd7
  } baud_sel_e;

  // Round-to-nearest integer division: clkHz / (baud * os).
  function automatic int baud_div(input int clkHz, input int baud, input int os);
    int den;
    den = baud * os;
    return (clkHz + den / 2) / den;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-N up counter with enable and synchronous clear.
//   Clk      - rising-edge clock
//   ResetN   - asynchronous active-low reset
//   en       - advance the count this cycle
//   clr      - force count to 0 (wins over en)
//   modulus  - counts 0..modulus-1 then wraps
//   count    - current count
//   terminal - high in the cycle the counter wraps (en && count == modulus-1)
module mod_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] count,
  output logic         terminal
);

  logic atLast;

  assign atLast   = (count == modulus - W'(1));
  assign terminal = en && !clr && atLast;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= atLast ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud tick generator shared by UART Tx and Rx.
//   Clk        - system clock, rising edge
//   ResetN     - asynchronous active-low reset
//   Enable     - run the generator; low holds counters and outputs cleared
//   Restart    - synchronous re-phase pulse (start-bit alignment)
//   BaudSel    - requested rate code (see uart_pkg::BAUD_RATES)
//   SelActive  - rate code currently in effect
//   OsTick     - one-cycle pulse at baud * OVERSAMPLE
//   MidBitTick - one-cycle pulse at the centre of each bit
//   BitTick    - one-cycle pulse at the end of each bit
//   BaudClk    - 50% duty square wave at the baud rate
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int DIV_W       = 16,
  parameter int RESET_SEL   = 2
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  Enable,
  input  logic                  Restart,
  input  logic [BAUD_SEL_W-1:0] BaudSel,
  output logic [BAUD_SEL_W-1:0] SelActive,
  output logic                  OsTick,
  output logic                  MidBitTick,
  output logic                  BitTick,
  output logic                  BaudClk
);

  localparam int OS_W = $clog2(OVERSAMPLE) + 1;

  localparam int DIV_TABLE [NUM_RATES] = '{
    baud_div(CLK_FREQ_HZ, BAUD_RATES[0], OVERSAMPLE),
    baud_div(CLK_FREQ_HZ, BAUD_RATES[1], OVERSAMPLE),
    baud_div(CLK_FREQ_HZ, BAUD_RATES[2], OVERSAMPLE),
    baud_div(CLK_FREQ_HZ, BAUD_RATES[3], OVERSAMPLE),
    baud_div(CLK_FREQ_HZ, BAUD_RATES[4], OVERSAMPLE),
    baud_div(CLK_FREQ_HZ, BAUD_RATES[5], OVERSAMPLE),
    baud_div(CLK_FREQ_HZ, BAUD_RATES[6], OVERSAMPLE),
    baud_div(CLK_FREQ_HZ, BAUD_RATES[7], OVERSAMPLE)
  };

  for (genvar i = 0; i < NUM_RATES; i++) begin : gDivCheck
    if (DIV_TABLE[i] < 2 || DIV_TABLE[i] > (2 ** DIV_W) - 1) begin : gBad
      $error("uart_baud_gen: divisor %0d for rate code %0d out of range", DIV_TABLE[i], i);
    end
  end

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : gOsCheck
    $error("uart_baud_gen: OVERSAMPLE must be even and at least 4");
  end

  logic                  run;
  logic [DIV_W-1:0]      divActive;
  logic [DIV_W-1:0]      divCnt;
  logic                  divTerm;
  logic [OS_W-1:0]       osCnt;
  logic                  osTerm;
  logic                  midWrap;
  logic [BAUD_SEL_W-1:0] selActive;
  logic [BAUD_SEL_W-1:0] selNext;
  logic                  pendValid;
  logic                  pendValidNext;
  logic [BAUD_SEL_W-1:0] pendSel;
  logic [BAUD_SEL_W-1:0] pendSelNext;

  // Disable and Restart share one path: both clear the counters and
  // suppress ticks, so an Enable rise is simply a restart.
  assign run = Enable && !Restart;

  always_comb begin
    divActive = DIV_W'(DIV_TABLE[selActive]);
  end

  // Counter stage: clock divider feeding the oversample counter.
  mod_counter #(.W(DIV_W)) uDivCounter (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .en       (run),
    .clr      (!run),
    .modulus  (divActive),
    .count    (divCnt),
    .terminal (divTerm)
  );

  mod_counter #(.W(OS_W)) uOsCounter (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .en       (divTerm),
    .clr      (!run),
    .modulus  (OS_W'(OVERSAMPLE)),
    .count    (osCnt),
    .terminal (osTerm)
  );

  // osTerm already implies a divider wrap at OsCnt == OVERSAMPLE-1.
  assign midWrap = divTerm && (osCnt == OS_W'(OVERSAMPLE / 2 - 1));

  // Rate selection. A request differing from the active rate waits in
  // Pending and only takes effect on a bit boundary, a restart or while
  // disabled; all three coincide with the divider being at 0, so the
  // divisor never changes mid-period. A request arriving on the boundary
  // cycle itself is queued for the following boundary. Returning BaudSel
  // to the active rate cancels a queued change.
  always_comb begin
    selNext       = selActive;
    pendValidNext = pendValid;
    pendSelNext   = pendSel;
    if (!run) begin
      selNext       = BaudSel;
      pendValidNext = 1'b0;
      pendSelNext   = BaudSel;
    end else begin
      if (osTerm && pendValid) begin
        selNext = pendSel;
      end
      pendValidNext = (BaudSel != selNext);
      pendSelNext   = BaudSel;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      selActive <= BAUD_SEL_W'(RESET_SEL);
      pendValid <= 1'b0;
      pendSel   <= '0;
    end else begin
      selActive <= selNext;
      pendValid <= pendValidNext;
      pendSel   <= pendSelNext;
    end
  end

  assign SelActive = selActive;

  // Output stage: ticks registered one cycle after the terminal count.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      OsTick     <= 1'b0;
      MidBitTick <= 1'b0;
      BitTick    <= 1'b0;
      BaudClk    <= 1'b0;
    end else if (!run) begin
      OsTick     <= 1'b0;
      MidBitTick <= 1'b0;
      BitTick    <= 1'b0;
      BaudClk    <= 1'b0;
    end else begin
      OsTick     <= divTerm;
      MidBitTick <= midWrap;
      BitTick    <= osTerm;
      if (midWrap) begin
        BaudClk <= 1'b1;
      end else if (osTerm) begin
        BaudClk <= 1'b0;
      end
    end
  end

  // Counters never pass their terminal value.
  assert property (@(posedge Clk) disable iff (!ResetN) divCnt < divActive);
  assert property (@(posedge Clk) disable iff (!ResetN) osCnt < OS_W'(OVERSAMPLE));

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised baud tick generator shared by UART Tx and Rx.
- Derives single-cycle enable pulses from the system clock, for eight selectable baud rates.
- Pulses: oversample tick, mid-bit sample tick, bit tick. Also a 50%-duty baud-rate square wave.
- Supports run-time rate change without glitches and a synchronous re-phase (Restart), which the Rx uses to align to a start-bit edge.

Parameters:
- CLK_FREQ_HZ, 50_000_000: system clock frequency.
- OVERSAMPLE, 16: oversample ticks per bit. Even, ≥4.
- DIV_W, 16: divider counter width.
- RESET_SEL, 2: selection applied out of reset (9600 baud).

Ports:
- Clk, in, 1: system clock, rising edge.
- ResetN, in, 1: asynchronous active-low reset.
- Enable, in, 1: run generator. Low holds everything cleared.
- Restart, in, 1: synchronous re-phase pulse.
- BaudSel, in, 3: requested rate. 0..7 = 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400.
- SelActive, out, 3: selection currently in effect.
- OsTick, out, 1: one-cycle pulse at baud*OVERSAMPLE.
- MidBitTick, out, 1: one-cycle pulse at bit centre.
- BitTick, out, 1: one-cycle pulse at end of each bit period.
- BaudClk, out, 1: square wave at baud rate.

Behaviour:
- Clocking and reset:
  - Single clock domain. ResetN is async assert, sync deassert (handled upstream).
  - All state is cleared on ResetN low.
- Divisor:
  - Div[sel] = round(CLK_FREQ_HZ / (baud[sel]*OVERSAMPLE)), computed at elaboration.
  - Elaboration error if any Div < 2 or Div > 2^DIV_W - 1.
  - At 50 MHz/16x: Div = 1302, 651, 326, 163, 81, 54, 27, 14.
- Reset values:
  - DivCnt = 0, OsCnt = 0.
  - OsTick, MidBitTick, BitTick, BaudClk = 0.
  - SelActive = RESET_SEL, Pending = none.
- Registered outputs: all outputs are registered. Ticks assert in the cycle after the counter reaches terminal.
- Divider (Enable=1, Restart=0):
  - DivCnt counts 0..Div-1, then wraps to 0.
  - At wrap, OsTick=1 in the next cycle.
- Oversample counter:
  - OsCnt increments on each divider wrap, modulo OVERSAMPLE.
  - MidBitTick pulses on the wrap where OsCnt == OVERSAMPLE/2-1.
  - BitTick pulses on the wrap where OsCnt == OVERSAMPLE-1.
- First ticks after Restart or Enable rise (cycle 0 = first counting cycle):
  - OsTick at Div cycles.
  - MidBitTick at (OVERSAMPLE/2)*Div.
  - BitTick at OVERSAMPLE*Div.
  - All then periodic with those periods.
- BaudClk: toggles to 1 with MidBitTick and to 0 with BitTick, giving 50% duty at the baud rate.
- Rate change:
  - BaudSel is sampled every cycle.
  - If it differs from SelActive, it is stored in the Pending register; later changes overwrite Pending.
  - Pending is applied (SelActive and Div updated, Pending cleared) only:
    - on a BitTick wrap cycle, or
    - when Restart=1, or
    - when Enable=0.
  - No partial bit at a mixed rate is ever produced.
- Enable=0:
  - Counters held at 0, all tick outputs 0, BaudClk 0.
  - Pending applied immediately.
  - Enable rising behaves as a Restart.
- Restart=1 (with Enable=1):
  - Counters forced to 0, no tick that cycle, Pending applied, BaudClk forced 0.
  - Restart wins over a coincident terminal count.
  - Consecutive Restart cycles keep the generator held.
- Simultaneous events:
  - Restart and BaudSel change in the same cycle: the new selection is used from the next cycle.
  - BitTick and BaudSel change in the same cycle: the change lands in Pending and is applied at the next bit boundary.
- Wrap: OsCnt and DivCnt never exceed terminal. A Div change always coincides with DivCnt == 0.
- Reset mid-operation: immediate clear of all outputs. After release, counting resumes with SelActive = RESET_SEL.

Decomposition:
- Package uart_pkg:
  - BAUD_SEL_W, the baud rate constant array.
  - Function baud_div(clk_hz, baud, os) returning rounded divisor.
  - Enum of selection codes.
- Sub-module mod_counter (parameter W):
  - Inputs: en, clr, modulus. Outputs: count, terminal pulse.
  - Instantiated twice: clock divider and oversample counter.

Test Plan (CLK_FREQ_HZ=50e6, OVERSAMPLE=16):
1. Reset release, Enable=1, BaudSel=2 → OsTick every 326 cycles, MidBitTick first at 2608, BitTick first at 5216 then every 5216; BaudClk period 5216, high 2608.
2. BaudSel=7 after Restart → OsTick every 14 cycles, MidBitTick at 112, BitTick at 224; SelActive=7 the cycle after Restart.
3. Change BaudSel 2→4 at cycle 1000 mid-bit → SelActive stays 2 until the BitTick at 5216, then BitTick spacing becomes 1296 (81×16); no short bit.
4. Restart pulse at cycle 3000 of a 9600 bit → all ticks suppressed; next MidBitTick at 3000+2608, BitTick at 3000+5216; BaudClk low from 3001.
5. Enable low for 50 cycles, BaudSel changed meanwhile → all outputs 0, SelActive updates within 1 cycle; on Enable high, first OsTick after Div cycles.
6. ResetN asserted asynchronously mid-bit (between clock edges) → all outputs 0 immediately, SelActive=2; counting restarts cleanly after release.
